note_sweep_ctrl: RTL and testbench
==================================

NOTE_SWEEP_CTRL -- requirements
Module: note_sweep_ctrl

Interface
REQ-001 Parameter window_p, default 6536: samples accumulated per note window (>=2).
REQ-002 Parameter notes_p, default 7: reference notes per sweep (2..8), index 0=A..6=G.
REQ-003 Parameter mag_width_p, default 32: width of magnitude input and result.
REQ-004 Parameter drain_p, default 6: cycles from last accumulated sample to expected magnitude.
REQ-005 clk_i  in  1  sole clock, all state rising-edge.
REQ-006 reset_ni  in  1  synchronous, active-low reset.
REQ-007 enable_i  in  1  level; high starts/continues sweeps.
REQ-008 sample_valid_i  in  1  audio sample available.
REQ-009 sample_ready_o  out  1  controller accepts sample this cycle.
REQ-010 note_sel_o  out  3  note/sinusoid select for datapath mux.
REQ-011 acc_clr_o  out  1  one-cycle clear pulse to accumulator.
REQ-012 acc_en_o  out  1  accumulate strobe, = sample_valid_i & sample_ready_o.
REQ-013 mag_i  in  mag_width_p  unsigned |correlation| of finished window.
REQ-014 mag_valid_i  in  1  mag_i valid.
REQ-015 result_note_o  out  3  winning note index of last completed sweep.
REQ-016 result_mag_o  out  mag_width_p  winning magnitude of last completed sweep.
REQ-017 result_valid_o  out  1  one-cycle pulse when results update.
REQ-018 busy_o  out  1  high in any state except IDLE.
REQ-019 timeout_o  out  1  sticky: a window's magnitude never arrived.

Function
REQ-020 FSM states IDLE, CLEAR, ACCUM, DRAIN, COMPARE; encoding free.
REQ-021 IDLE: sample_ready_o=0; enable_i=1 -> CLEAR with note=0, best_mag=0, best_note=0.
REQ-022 CLEAR: acc_clr_o=1 exactly one cycle, sample_ready_o=0, sample count=0; -> ACCUM next cycle.
REQ-023 ACCUM: sample_ready_o=1; each handshake increments count (width clog2(window_p)); handshake at count=window_p-1 -> DRAIN.
REQ-024 ACCUM with sample_valid_i=0: hold state and count; no timeout in ACCUM.
REQ-025 DRAIN: sample_ready_o=0; wait counter starts 0; mag_valid_i=1 -> COMPARE latching mag_i.
REQ-026 DRAIN without mag_valid_i for drain_p+4 cycles: latch magnitude 0, set timeout_o, -> COMPARE.
REQ-027 mag_valid_i outside DRAIN is ignored.
REQ-028 COMPARE: latched mag strictly greater than best_mag -> best_mag, best_note update; ties keep lower index.
REQ-029 COMPARE with note<notes_p-1: note+1, -> CLEAR.
REQ-030 COMPARE with note=notes_p-1: result_note_o/result_mag_o load the best (including this window's), result_valid_o pulses one cycle; enable_i=1 -> CLEAR with note=0 and best cleared, else -> IDLE.
REQ-031 enable_i deassertion mid-sweep does not abort; sweep completes, then IDLE.
REQ-032 note_sel_o = current note in all states; 0 in IDLE.
REQ-033 acc_clr_o and acc_en_o never high in the same cycle.
REQ-034 Sweep duration with continuous samples and mag at drain_p: notes_p*(window_p+drain_p+2) cycles.

Reset
REQ-035 reset_ni=0 at a clock edge: state IDLE, count 0, note 0, best 0, outputs sample_ready_o, acc_clr_o, acc_en_o, busy_o, result_valid_o, timeout_o = 0, result_note_o=0, result_mag_o=0.
REQ-036 Reset mid-sweep discards partial results; no result_valid_o pulse; takes priority over all inputs.
REQ-037 timeout_o clears only on reset.

Verification (window_p=4, notes_p=3, drain_p=2)
REQ-038 Reset low 2 cycles then high, enable_i=0 -> all outputs 0, busy_o=0, indefinitely.
REQ-039 enable_i=1, continuous samples, mags 10,50,30 at drain_p -> result_note_o=1, result_mag_o=50, one result_valid_o pulse, sweep 3*(4+2+2)=24 cycles.
REQ-040 Mags 40,40,12 -> result_note_o=0 (tie keeps lower index), result_mag_o=40.
REQ-041 sample_valid_i toggled 1/0 in ACCUM -> exactly 4 acc_en_o pulses per window, count holds on gaps.
REQ-042 mag_valid_i never asserted for note 1 -> DRAIN exits after 6 cycles, timeout_o=1 sticky, note 1 treated as 0.
REQ-043 reset_ni low during note 2 ACCUM -> IDLE next cycle, no result_valid_o, result_mag_o=0.

Source files
------------

// File: rtl/note_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// note_sweep_ctrl
//
// Sequences a note-detection sweep over a correlation datapath. For each
// reference note the controller clears the accumulator, accepts window_p
// audio samples, waits for the datapath to report the window's correlation
// magnitude and then keeps a running maximum. After the last note the
// winning note index and magnitude are published with a one-cycle strobe.
//
// Ports
//   clk_i          : sole clock, all state updates on the rising edge
//   reset_ni       : synchronous active-low reset
//   enable_i       : level, high starts (and keeps restarting) sweeps
//   sample_valid_i : an audio sample is offered
//   sample_ready_o : controller takes the offered sample this cycle
//   note_sel_o     : note/sinusoid select for the datapath mux
//   acc_clr_o      : one-cycle accumulator clear
//   acc_en_o       : accumulate strobe (sample handshake)
//   mag_i          : unsigned |correlation| of the finished window
//   mag_valid_i    : mag_i is valid
//   result_note_o  : winning note of the last completed sweep
//   result_mag_o   : winning magnitude of the last completed sweep
//   result_valid_o : one-cycle pulse when the results update
//   busy_o         : high whenever a sweep is in progress
//   timeout_o      : sticky, some window's magnitude never arrived
// ---------------------------------------------------------------------------
module note_sweep_ctrl #(
   parameter int window_p    = 6536,
   parameter int notes_p     = 7,
   parameter int mag_width_p = 32,
   parameter int drain_p     = 6
) (
   input  logic                   clk_i,
   input  logic                   reset_ni,
   input  logic                   enable_i,
   input  logic                   sample_valid_i,
   output logic                   sample_ready_o,
   output logic [2:0]             note_sel_o,
   output logic                   acc_clr_o,
   output logic                   acc_en_o,
   input  logic [mag_width_p-1:0] mag_i,
   input  logic                   mag_valid_i,
   output logic [2:0]             result_note_o,
   output logic [mag_width_p-1:0] result_mag_o,
   output logic                   result_valid_o,
   output logic                   busy_o,
   output logic                   timeout_o
);

   localparam int cnt_w  = (window_p > 1) ? $clog2(window_p) : 1;
   // The wait counter must reach drain_p+3, the last cycle spent in DRAIN.
   localparam int wait_w = $clog2(drain_p + 5);

   localparam logic [cnt_w-1:0]  cnt_last  = cnt_w'(window_p - 1);
   localparam logic [wait_w-1:0] wait_last = wait_w'(drain_p + 3);
   localparam logic [2:0]        note_last = 3'(notes_p - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      ACCUM   = 3'd2,
      DRAIN   = 3'd3,
      COMPARE = 3'd4
   } state_t;

   state_t state_reg, state_next;

   logic [cnt_w-1:0]       cnt_reg;
   logic [wait_w-1:0]      wait_reg;
   logic [2:0]             note_reg;
   logic [mag_width_p-1:0] mag_reg;
   logic [mag_width_p-1:0] best_mag_reg;
   logic [2:0]             best_note_reg;
   logic [2:0]             res_note_reg;
   logic [mag_width_p-1:0] res_mag_reg;
   logic                   res_valid_reg;
   logic                   timeout_reg;

   logic                   handshake;
   logic                   wins;
   logic [mag_width_p-1:0] win_mag;
   logic [2:0]             win_note;

   assign handshake = sample_valid_i && (state_reg == ACCUM);

   // Strict greater-than: on a tie the earlier (lower index) note stays best.
   assign wins     = (mag_reg > best_mag_reg);
   assign win_mag  = wins ? mag_reg  : best_mag_reg;
   assign win_note = wins ? note_reg : best_note_reg;

   // ---------------- state register ----------------
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (enable_i) state_next = CLEAR;
         end
         CLEAR: begin
            state_next = ACCUM;
         end
         ACCUM: begin
            if (handshake && (cnt_reg == cnt_last)) state_next = DRAIN;
         end
         DRAIN: begin
            if (mag_valid_i || (wait_reg == wait_last)) state_next = COMPARE;
         end
         COMPARE: begin
            // enable_i only matters once the whole sweep has finished.
            if (note_reg != note_last) state_next = CLEAR;
            else if (enable_i)         state_next = CLEAR;
            else                       state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      sample_ready_o = 1'b0;
      acc_clr_o      = 1'b0;
      busy_o         = 1'b1;
      note_sel_o     = note_reg;
      case (state_reg)
         IDLE: begin
            busy_o     = 1'b0;
            note_sel_o = 3'd0;
         end
         CLEAR: begin
            acc_clr_o = 1'b1;
         end
         ACCUM: begin
            sample_ready_o = 1'b1;
         end
         default: begin
         end
      endcase
      // Only asserted in ACCUM, so it can never overlap the CLEAR pulse.
      acc_en_o = sample_valid_i & sample_ready_o;
   end

   assign result_note_o  = res_note_reg;
   assign result_mag_o   = res_mag_reg;
   assign result_valid_o = res_valid_reg;
   assign timeout_o      = timeout_reg;

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         cnt_reg       <= '0;
         wait_reg      <= '0;
         note_reg      <= '0;
         mag_reg       <= '0;
         best_mag_reg  <= '0;
         best_note_reg <= '0;
         res_note_reg  <= '0;
         res_mag_reg   <= '0;
         res_valid_reg <= 1'b0;
         timeout_reg   <= 1'b0;
      end else begin
         res_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (enable_i) begin
                  note_reg      <= '0;
                  best_mag_reg  <= '0;
                  best_note_reg <= '0;
               end
            end
            CLEAR: begin
               cnt_reg <= '0;
            end
            ACCUM: begin
               // Arm the drain wait counter so it starts at zero in DRAIN.
               wait_reg <= '0;
               if (handshake) cnt_reg <= cnt_reg + cnt_w'(1);
            end
            DRAIN: begin
               if (mag_valid_i) begin
                  mag_reg <= mag_i;
               end else if (wait_reg == wait_last) begin
                  // Missing magnitude: score the window as zero.
                  mag_reg     <= '0;
                  timeout_reg <= 1'b1;
               end else begin
                  wait_reg <= wait_reg + wait_w'(1);
               end
            end
            COMPARE: begin
               if (note_reg != note_last) begin
                  best_mag_reg  <= win_mag;
                  best_note_reg <= win_note;
                  note_reg      <= note_reg + 3'd1;
               end else begin
                  // Publish the sweep winner and start the next sweep clean.
                  res_mag_reg   <= win_mag;
                  res_note_reg  <= win_note;
                  res_valid_reg <= 1'b1;
                  note_reg      <= '0;
                  best_mag_reg  <= '0;
                  best_note_reg <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_sweep_ctrl.sv
module tb_note_sweep_ctrl;

   localparam int W  = 4;
   localparam int N  = 3;
   localparam int D  = 2;
   localparam int MW = 32;

   logic          clk_i = 1'b0;
   logic          reset_ni;
   logic          enable_i;
   logic          sample_valid_i;
   logic          sample_ready_o;
   logic [2:0]    note_sel_o;
   logic          acc_clr_o;
   logic          acc_en_o;
   logic [MW-1:0] mag_i;
   logic          mag_valid_i;
   logic [2:0]    result_note_o;
   logic [MW-1:0] result_mag_o;
   logic          result_valid_o;
   logic          busy_o;
   logic          timeout_o;

   always #5 clk_i = ~clk_i;

   note_sweep_ctrl #(
      .window_p(W), .notes_p(N), .mag_width_p(MW), .drain_p(D)
   ) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(enable_i),
      .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
      .note_sel_o(note_sel_o), .acc_clr_o(acc_clr_o), .acc_en_o(acc_en_o),
      .mag_i(mag_i), .mag_valid_i(mag_valid_i),
      .result_note_o(result_note_o), .result_mag_o(result_mag_o),
      .result_valid_o(result_valid_o), .busy_o(busy_o), .timeout_o(timeout_o)
   );

   typedef struct {
      bit            skip;
      logic [MW-1:0] mag;
   } win_t;

   typedef struct {
      logic [2:0]    note;
      logic [MW-1:0] mag;
   } res_t;

   win_t win_q[$];   // magnitudes the datapath model returns, one per window
   res_t sb_q[$];    // expected sweep results, in order

   int total = 0;
   int bad   = 0;
   int rv_count = 0;

   // responder / monitor state
   int            win_cnt  = 0;
   int            pend     = 0;
   int            post_cnt = 0;
   bit            in_post  = 1'b0;
   bit            cur_skip = 1'b0;
   bit            prev_ready = 1'b0;
   logic [MW-1:0] pend_mag = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      total++;
      bad++;
      $error("FAIL %s observed=missing expected=present", tag);
   endtask

   // Reference winner: strictly larger magnitude wins, ties keep lower index.
   function automatic res_t best_of(input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                                    input logic [MW-1:0] m2);
      logic [MW-1:0] m [3];
      res_t r;
      m[0] = m0; m[1] = m1; m[2] = m2;
      r.note = 3'd0;
      r.mag  = '0;
      for (int i = 0; i < N; i++) begin
         if (m[i] > r.mag) begin
            r.mag  = m[i];
            r.note = 3'(i);
         end
      end
      return r;
   endfunction

   // Queue one sweep: windows for the responder and, if expected, a result.
   task automatic push_sweep(input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                             input logic [MW-1:0] m2, input bit skip1, input bit expect_res);
      win_t w;
      w.skip = 1'b0; w.mag = m0; win_q.push_back(w);
      w.skip = skip1; w.mag = m1; win_q.push_back(w);
      w.skip = 1'b0; w.mag = m2; win_q.push_back(w);
      if (expect_res) sb_q.push_back(best_of(m0, skip1 ? '0 : m1, m2));
   endtask

   // Runs n_res back-to-back sweeps, dropping enable once the last one starts.
   task automatic run_sweeps(input int n_res, input bit gaps, output int busy_cyc);
      int start_rv;
      int guard;
      start_rv = rv_count;
      guard    = 0;
      busy_cyc = 0;
      enable_i = 1'b1;
      while (guard < 3000) begin
         @(negedge clk_i);
         guard++;
         sample_valid_i = gaps ? ~sample_valid_i : 1'b1;
         if (rv_count - start_rv >= n_res - 1) enable_i = 1'b0;
         if (busy_o) busy_cyc++;
         else if (busy_cyc > 0) break;
      end
      if (guard >= 3000) fail_now("sweep_end_timeout");
      repeat (2) @(negedge clk_i);
      chk("result_pulses", rv_count - start_rv, n_res);
   endtask

   // Datapath model and output monitor, sampled just after the falling edge.
   always begin
      @(negedge clk_i);
      #1;
      if (mag_valid_i) mag_valid_i = 1'b0;
      if (!reset_ni) begin
         win_q.delete();
         win_cnt  = 0;
         pend     = 0;
         in_post  = 1'b0;
         post_cnt = 0;
      end else begin
         chk("clr_en_exclusive", {acc_clr_o & acc_en_o}, 1'b0);
         if (acc_en_o) win_cnt++;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mag_valid_i = 1'b1;
               mag_i       = pend_mag;
            end
         end
         if (in_post) begin
            if (busy_o && !sample_ready_o && !acc_clr_o) begin
               post_cnt++;
            end else begin
               chk(cur_skip ? "drain_timeout_len" : "drain_len", post_cnt,
                   cur_skip ? (D + 5) : (D + 1));
               in_post = 1'b0;
            end
         end
         if (prev_ready && !sample_ready_o && busy_o) begin
            chk("window_handshakes", win_cnt, W);
            win_cnt  = 0;
            in_post  = 1'b1;
            post_cnt = 1;
            if (win_q.size() == 0) begin
               fail_now("window_queue");
               cur_skip = 1'b0;
            end else begin
               win_t w;
               w = win_q.pop_front();
               cur_skip = w.skip;
               if (w.skip) begin
                  mag_i = w.mag;   // bus carries data but valid never rises
               end else if (D <= 1) begin
                  mag_valid_i = 1'b1;
                  mag_i       = w.mag;
               end else begin
                  pend     = D - 1;
                  pend_mag = w.mag;
               end
            end
         end
         if (result_valid_o) begin
            rv_count++;
            $display("result note=%0d mag=%0d", result_note_o, result_mag_o);
            if (sb_q.size() == 0) begin
               fail_now("unexpected_result");
            end else begin
               res_t e;
               e = sb_q.pop_front();
               chk("result_note", result_note_o, e.note);
               chk("result_mag", result_mag_o, e.mag);
            end
         end
      end
      prev_ready = sample_ready_o;
   end

   initial begin
      int cyc;
      int guard;
      int start_rv;
      reset_ni       = 1'b0;
      enable_i       = 1'b0;
      sample_valid_i = 1'b0;
      mag_i          = '0;
      mag_valid_i    = 1'b0;
      repeat (2) @(negedge clk_i);
      reset_ni = 1'b1;

      // Idle with enable low: everything stays quiet even with samples offered.
      sample_valid_i = 1'b1;
      repeat (6) begin
         @(negedge clk_i);
         chk("idle_outputs", {busy_o, sample_ready_o, acc_clr_o, acc_en_o, result_valid_o,
                              timeout_o, note_sel_o, result_note_o}, 12'd0);
         chk("idle_result_mag", result_mag_o, 0);
      end

      // Single sweep, distinct magnitudes.
      push_sweep(10, 50, 30, 1'b0, 1'b1);
      run_sweeps(1, 1'b0, cyc);
      $display("sweep A busy=%0d", cyc);
      chk("sweepA_cycles", cyc, N * (W + D + 2));
      chk("sweepA_note_held", result_note_o, 1);
      chk("sweepA_mag_held", result_mag_o, 50);

      // Two back-to-back sweeps: tie at the top, then enable dropped mid-sweep.
      push_sweep(40, 40, 12, 1'b0, 1'b1);
      push_sweep(7, 7, 9, 1'b0, 1'b1);
      run_sweeps(2, 1'b0, cyc);
      $display("sweeps B+C busy=%0d", cyc);
      chk("sweepBC_cycles", cyc, 2 * N * (W + D + 2));
      chk("sweepC_note_held", result_note_o, 2);

      // Samples offered every other cycle.
      push_sweep(5, 6, 7, 1'b0, 1'b1);
      run_sweeps(1, 1'b1, cyc);
      $display("sweep D busy=%0d", cyc);
      chk("sweepD_longer", {cyc > N * (W + D + 2)}, 1'b1);
      sample_valid_i = 1'b1;
      chk("timeout_before", timeout_o, 1'b0);

      // Missing magnitude for note 1 (a large value sits on the bus unvalidated).
      push_sweep(20, 99, 15, 1'b1, 1'b1);
      run_sweeps(1, 1'b0, cyc);
      $display("sweep E busy=%0d", cyc);
      chk("sweepE_cycles", cyc, N * (W + D + 2) + 4);
      chk("timeout_set", timeout_o, 1'b1);

      // Normal sweep afterwards: timeout remains sticky.
      push_sweep(1, 2, 3, 1'b0, 1'b1);
      run_sweeps(1, 1'b0, cyc);
      chk("timeout_sticky", timeout_o, 1'b1);
      chk("sweepF_mag_held", result_mag_o, 3);

      // Reset in the ACCUM phase of note 2: no result, everything cleared.
      push_sweep(11, 12, 13, 1'b0, 1'b0);
      start_rv = rv_count;
      enable_i = 1'b1;
      guard    = 0;
      while (guard < 500) begin
         @(negedge clk_i);
         guard++;
         enable_i = 1'b0;
         if (note_sel_o == 3'd2 && sample_ready_o) break;
      end
      if (guard >= 500) fail_now("reach_note2_accum");
      reset_ni = 1'b0;
      @(negedge clk_i);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_ready_en", {sample_ready_o, acc_en_o, acc_clr_o}, 3'd0);
      chk("rst_result_mag", result_mag_o, 0);
      chk("rst_result_note", result_note_o, 0);
      chk("rst_timeout", timeout_o, 1'b0);
      chk("rst_note_sel", note_sel_o, 0);
      @(negedge clk_i);
      reset_ni = 1'b1;
      repeat (8) @(negedge clk_i);
      chk("rst_stays_idle", busy_o, 1'b0);
      chk("rst_no_result", rv_count - start_rv, 0);
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
